// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe: request side (in_*) and response side (out_*).
// Master drives operands and out_ready; slave (the ALU) drives in_ready and the result register.
interface alu_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

    modport master (
        output in_valid, opcode, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, opcode, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/alu_pipe.sv
// 16-op registered ALU; 1-cycle latency, MUL takes WIDTH cycles via iterative shift-add.
// Backpressure: one-entry output register; while it is full and not drained, in_ready stays low.
module alu_pipe #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input logic       clk,
    input logic       rst_n,
    alu_pipe_if.slave bus
);
    localparam int LW = $clog2(WIDTH);
    localparam int M  = WIDTH - 1;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state_q, state_d;
    logic [LW-1:0]    count_q;
    logic [WIDTH-1:0] ma_q, mb_q, acc_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic             out_valid_q;

    logic             in_rdy, accept, mul_start, mul_done;
    logic [WIDTH-1:0] mul_prod;

    logic [LW-1:0]    shamt;
    logic [WIDTH:0]   add_w, sub_w, inc_w, dec_w, shl_w, shr_w, sra_w;
    logic signed [WIDTH:0] sra_in;
    logic             add_v, sub_v;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c, alu_v;

    assign in_rdy    = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept    = bus.in_valid && in_rdy;
    assign mul_start = accept && (bus.opcode == 4'd14) && MUL_EN;
    assign mul_done  = (state_q == MUL) && (count_q == LW'(WIDTH - 1));
    assign mul_prod  = acc_q + (mb_q[0] ? ma_q : '0);

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

    // Extra MSB on each arithmetic result carries the carry/borrow; extra LSB on right shifts catches the bit shifted out.
    assign shamt  = bus.b[LW-1:0];
    assign add_w  = {1'b0, bus.a} + {1'b0, bus.b};
    assign sub_w  = {1'b0, bus.a} - {1'b0, bus.b};
    assign inc_w  = {1'b0, bus.a} + (WIDTH+1)'(1);
    assign dec_w  = {1'b0, bus.a} - (WIDTH+1)'(1);
    assign shl_w  = {1'b0, bus.a} << shamt;
    assign shr_w  = {bus.a, 1'b0} >> shamt;
    assign sra_in = {bus.a, 1'b0};
    assign sra_w  = sra_in >>> shamt;
    assign add_v  = (bus.a[M] == bus.b[M]) && (add_w[M] != bus.a[M]);
    assign sub_v  = (bus.a[M] != bus.b[M]) && (sub_w[M] != bus.a[M]);

    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (bus.opcode)
            4'd0:  begin alu_r = add_w[M:0]; alu_c = add_w[WIDTH]; alu_v = add_v; end
            4'd1:  begin alu_r = sub_w[M:0]; alu_c = sub_w[WIDTH]; alu_v = sub_v; end
            4'd2:  alu_r = bus.a & bus.b;
            4'd3:  alu_r = bus.a | bus.b;
            4'd4:  alu_r = bus.a ^ bus.b;
            4'd5:  alu_r = ~(bus.a & bus.b);
            4'd6:  alu_r = ~(bus.a | bus.b);
            4'd7:  alu_r = ~bus.a;
            4'd8:  begin alu_r = shl_w[M:0];     alu_c = shl_w[WIDTH]; end
            4'd9:  begin alu_r = shr_w[WIDTH:1]; alu_c = shr_w[0]; end
            4'd10: begin alu_r = sra_w[WIDTH:1]; alu_c = sra_w[0]; end
            4'd11: alu_r = bus.b;
            4'd12: begin
                alu_r = inc_w[M:0];
                alu_c = inc_w[WIDTH];
                alu_v = !bus.a[M] && inc_w[M];
            end
            4'd13: begin
                alu_r = dec_w[M:0];
                alu_c = dec_w[WIDTH];
                alu_v = bus.a[M] && !dec_w[M];
            end
            4'd14: alu_r = '0;
            4'd15: begin
                // Signed less-than is the sign of a-b corrected by its overflow.
                alu_r = {{(WIDTH-1){1'b0}}, sub_w[M] ^ sub_v};
                alu_c = sub_w[WIDTH];
                alu_v = sub_v;
            end
            default: alu_r = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mul_start) state_d = MUL;
            MUL:     if (mul_done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            ma_q        <= '0;
            mb_q        <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (state_q == MUL) begin
                acc_q   <= mul_prod;
                ma_q    <= ma_q << 1;
                mb_q    <= mb_q >> 1;
                count_q <= count_q + LW'(1);
            end
            if (mul_start) begin
                ma_q    <= bus.a;
                mb_q    <= bus.b;
                acc_q   <= '0;
                count_q <= '0;
            end

            if (mul_done) begin
                result_q    <= mul_prod;
                flags_q     <= {2'b00, mul_prod[M], mul_prod == '0};
                out_valid_q <= 1'b1;
            end else if (accept && !mul_start) begin
                result_q    <= alu_r;
                flags_q     <= {alu_v, alu_c, alu_r[M], alu_r == '0};
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                // Also covers MUL start: acceptance implies the old result drains on this edge.
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: literal per-vector expectations plus a cycle-by-cycle scoreboard
// fed by an arithmetic reference model of the opcode table.
module tb_alu_pipe;
    localparam int W = 16;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    int   cyc;

    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic [3:0]   f;
        int           due;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode table, returns {V,C,N,Z,result}.
    function automatic logic [W+3:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint ua, ub, sa, sb_, r, full, smax, smin;
        int     sh;
        bit     c, v;
        logic [W-1:0] res;
        full = longint'(1) << W;
        smax = (full / 2) - 1;
        smin = -(full / 2);
        ua = longint'(a);
        ub = longint'(b);
        sa = a[W-1] ? ua - full : ua;
        sb_ = b[W-1] ? ub - full : ub;
        sh = int'(b[$clog2(W)-1:0]);
        r = 0; c = 0; v = 0;
        case (op)
            4'd0:  begin r = ua + ub; c = (r >= full); v = (sa + sb_ > smax) || (sa + sb_ < smin); end
            4'd1:  begin r = ua - ub; c = (ua < ub);   v = (sa - sb_ > smax) || (sa - sb_ < smin); end
            4'd2:  r = ua & ub;
            4'd3:  r = ua | ub;
            4'd4:  r = ua ^ ub;
            4'd5:  r = ~(ua & ub);
            4'd6:  r = ~(ua | ub);
            4'd7:  r = ~ua;
            4'd8:  begin r = ua << sh;  c = (sh > 0) && (((ua >> (W - sh)) & 1) == 1); end
            4'd9:  begin r = ua >> sh;  c = (sh > 0) && (((ua >> (sh - 1)) & 1) == 1); end
            4'd10: begin r = sa >>> sh; c = (sh > 0) && (((ua >> (sh - 1)) & 1) == 1); end
            4'd11: r = ub;
            4'd12: begin r = ua + 1; c = (r >= full); v = (sa + 1 > smax); end
            4'd13: begin r = ua - 1; c = (ua == 0);   v = (sa - 1 < smin); end
            4'd14: r = ua * ub;
            default: begin
                r = (sa < sb_) ? 1 : 0;
                c = (ua < ub);
                v = (sa - sb_ > smax) || (sa - sb_ < smin);
            end
        endcase
        res = r[W-1:0];
        return {v, c, res[W-1], res == '0, res};
    endfunction

    // Scoreboard: checks out_valid/in_ready timing and every presented result.
    always @(negedge clk) begin
        logic  exp_ov, exp_ir;
        logic [W+3:0] m;
        exp_t  e;
        if (!rst_n) begin
            sb.delete();
            chk("rst_ovld", {31'd0, bus.out_valid}, 32'd0);
        end else begin
            cyc++;
            exp_ov = (sb.size() > 0) && (sb[0].due <= cyc);
            chk("ovld", {31'd0, bus.out_valid}, {31'd0, exp_ov});
            if (exp_ov && bus.out_valid) begin
                chk("sb_result", {16'd0, bus.result}, {16'd0, sb[0].r});
                chk("sb_flags", {28'd0, bus.flags}, {28'd0, sb[0].f});
            end
            exp_ir = !((sb.size() > 0) && (sb[0].due > cyc)) && (!exp_ov || bus.out_ready);
            chk("irdy", {31'd0, bus.in_ready}, {31'd0, exp_ir});
            if (exp_ov && bus.out_ready) void'(sb.pop_front());
            if (bus.in_valid && exp_ir) begin
                m     = model(bus.opcode, bus.a, bus.b);
                e.r   = m[W-1:0];
                e.f   = m[W+3:W];
                e.due = cyc + ((bus.opcode == 4'd14) ? W + 1 : 1);
                sb.push_back(e);
            end
        end
    end

    // Present one op; returns one tick after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok;
        ok = 0;
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.a        = a;
        bus.b        = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            miscompares++;
            $display("FAIL issue_timeout: op %0d never accepted", op);
        end
    endtask

    task automatic run_vec(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] er, input logic [3:0] ef);
        issue(op, a, b);
        for (int i = 0; i < W + 4 && !bus.out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chk($sformatf("vec_op%0d_valid", op), {31'd0, bus.out_valid}, 32'd1);
        chk($sformatf("vec_op%0d_result", op), {16'd0, bus.result}, {16'd0, er});
        chk($sformatf("vec_op%0d_flags", op), {28'd0, bus.flags}, {28'd0, ef});
    endtask

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a, b, r;
        logic [3:0]   f;
    } vec_t;

    vec_t vt[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.opcode = 4'd0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
        #3;
        chk("reset_ovld", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_result", {16'd0, bus.result}, 32'd0);
        chk("reset_flags", {28'd0, bus.flags}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_reset_irdy", {31'd0, bus.in_ready}, 32'd1);

        // {op, a, b, result, {V,C,N,Z}}
        vt = '{
            '{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'b1010},
            '{4'd1,  16'h0000, 16'h0001, 16'hFFFF, 4'b0110},
            '{4'd15, 16'hFFFF, 16'h0001, 16'h0001, 4'b0000},
            '{4'd10, 16'h8001, 16'h0001, 16'hC000, 4'b0110},
            '{4'd8,  16'h8001, 16'h0000, 16'h8001, 4'b0010},
            '{4'd14, 16'h0123, 16'h0045, 16'h4E6F, 4'b0000},
            '{4'd2,  16'h00FF, 16'h0F0F, 16'h000F, 4'b0000},
            '{4'd3,  16'h00FF, 16'h0F0F, 16'h0FFF, 4'b0000},
            '{4'd5,  16'h00FF, 16'h0F0F, 16'hFFF0, 4'b0010},
            '{4'd6,  16'h00FF, 16'h0F0F, 16'hF000, 4'b0010},
            '{4'd7,  16'h00FF, 16'h1234, 16'hFF00, 4'b0010},
            '{4'd11, 16'hABCD, 16'h0000, 16'h0000, 4'b0001},
            '{4'd12, 16'h7FFF, 16'h0000, 16'h8000, 4'b1010},
            '{4'd12, 16'hFFFF, 16'h0000, 16'h0000, 4'b0101},
            '{4'd13, 16'h0000, 16'h0000, 16'hFFFF, 4'b0110},
            '{4'd13, 16'h8000, 16'h0000, 16'h7FFF, 4'b1000},
            '{4'd9,  16'h8001, 16'h0004, 16'h0800, 4'b0000},
            '{4'd9,  16'h000F, 16'h0001, 16'h0007, 4'b0100},
            '{4'd8,  16'h8001, 16'h0001, 16'h0002, 4'b0100},
            '{4'd10, 16'h8000, 16'h000F, 16'hFFFF, 4'b0010},
            '{4'd1,  16'h8000, 16'h0001, 16'h7FFF, 4'b1000},
            '{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 4'b0101},
            '{4'd15, 16'h0001, 16'hFFFF, 16'h0000, 4'b0101},
            '{4'd15, 16'h8000, 16'h0001, 16'h0001, 4'b1000},
            '{4'd4,  16'h00FF, 16'h0F0F, 16'h0FF0, 4'b0000},
            '{4'd14, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0000},
            '{4'd14, 16'h0100, 16'h0100, 16'h0000, 4'b0001}
        };
        foreach (vt[i]) run_vec(vt[i].op, vt[i].a, vt[i].b, vt[i].r, vt[i].f);

        // MUL busy window: in_ready and out_valid low for WIDTH edges after acceptance.
        issue(4'd14, 16'h0123, 16'h0045);
        for (int i = 0; i < W; i++) begin
            chk("mul_busy_irdy", {31'd0, bus.in_ready}, 32'd0);
            chk("mul_busy_ovld", {31'd0, bus.out_valid}, 32'd0);
            @(posedge clk); #1;
        end
        chk("mul_done_ovld", {31'd0, bus.out_valid}, 32'd1);
        chk("mul_done_result", {16'd0, bus.result}, 32'h4E6F);
        chk("mul_done_flags", {28'd0, bus.flags}, 32'd0);
        @(posedge clk); #1;

        // Backpressure: ADD result must hold while XOR waits.
        bus.out_ready = 1'b0;
        issue(4'd0, 16'h0002, 16'h0003);
        bus.in_valid = 1'b1; bus.opcode = 4'd4; bus.a = 16'h00FF; bus.b = 16'h0F0F;
        for (int i = 0; i < 5; i++) begin
            chk("hold_ovld", {31'd0, bus.out_valid}, 32'd1);
            chk("hold_result", {16'd0, bus.result}, 32'h0005);
            chk("hold_irdy", {31'd0, bus.in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("drain_accept_result", {16'd0, bus.result}, 32'h0FF0);
        chk("drain_accept_ovld", {31'd0, bus.out_valid}, 32'd1);

        // Streaming: one result per cycle.
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1; bus.opcode = 4'd0; bus.a = 16'(i * 3); bus.b = 16'h0010;
            chk("stream_irdy", {31'd0, bus.in_ready}, 32'd1);
            @(posedge clk); #1;
            chk("stream_ovld", {31'd0, bus.out_valid}, 32'd1);
            chk("stream_result", {16'd0, bus.result}, 32'(i * 3 + 16));
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("stream_end_ovld", {31'd0, bus.out_valid}, 32'd0);

        // Asynchronous reset mid-MUL (count=7).
        issue(4'd14, 16'h0123, 16'h0045);
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midmul_rst_ovld", {31'd0, bus.out_valid}, 32'd0);
        chk("midmul_rst_result", {16'd0, bus.result}, 32'd0);
        chk("midmul_rst_flags", {28'd0, bus.flags}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midmul_release_irdy", {31'd0, bus.in_ready}, 32'd1);
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            chk("no_stale_product", {31'd0, bus.out_valid}, 32'd0);
        end
        run_vec(4'd0, 16'h1111, 16'h2222, 16'h3333, 4'b0000);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the 16-bit ALU.
- Performs one of 16 operations on two WIDTH-bit operands and returns a result with a status-flag nibble.
- Operands come in through a valid/ready handshake and results go out through a second valid/ready handshake with a one-entry output register.
- Single-cycle ops have 1-cycle latency. Multiply is an optional iterative shift-add unit.

Parameters:
- WIDTH, 16, operand/result width. Must be a power of two, >= 4.
- MUL_EN, 1, 1 = iterative multiplier present; 0 = opcode 14 returns 0 in 1 cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept an operation this cycle.
- opcode  in  4  operation select.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- flags  out  4  {V,C,N,Z}, registered alongside result.

Behaviour:
- Reset (async, rst_n=0):
  - FSM returns to IDLE.
  - out_valid=0, result=0, flags=0, iteration counter=0.
  - Any in-flight MUL is discarded.
  - in_ready comes up 1 the first cycle after rst_n deasserts.
- Acceptance: an operation is accepted on a rising edge when in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Accepting while the output is drained in the same cycle is legal, so back-to-back ops give 1 result/cycle.
- Result consumption: result is consumed on an edge where out_valid && out_ready. out_valid then drops unless a new result loads on the same edge.
- Hold rule: while out_valid && !out_ready, result and flags hold stable and no new op is accepted.
- Opcodes; shamt = b[log2(WIDTH)-1:0]; arithmetic is modulo 2^WIDTH:
  - 0 ADD a+b
  - 1 SUB a-b
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NAND
  - 6 NOR
  - 7 NOT a (b ignored)
  - 8 SHL a<<shamt
  - 9 SHR logical
  - 10 SRA arithmetic
  - 11 PASS b
  - 12 INC a+1
  - 13 DEC a-1
  - 14 MUL low WIDTH bits of a*b, unsigned
  - 15 SLT: 1 if signed a<b, else 0
- Flags:
  - Z = (result==0).
  - N = result[WIDTH-1].
  - C:
    - carry-out for ADD/INC;
    - borrow (unsigned a<b, or a==0 for DEC) for SUB/DEC/SLT;
    - last bit shifted out for SHL/SHR/SRA (0 when shamt=0);
    - 0 otherwise.
  - V: signed overflow for ADD/SUB/INC/DEC/SLT (SLT uses the a-b overflow); 0 otherwise.
- Latency, single-cycle ops (all except MUL with MUL_EN=1): accepted on edge k, out_valid=1 after edge k.
- FSM states: IDLE and MUL.
  - IDLE -> MUL on acceptance of opcode 14 when MUL_EN=1. This latches a, b, clears the accumulator and sets count=0.
  - MUL performs one shift-add iteration per cycle. count increments each cycle.
  - On the edge where count==WIDTH-1, the final product loads into result, flags update, out_valid=1, and the FSM returns to IDLE.
  - MUL accepted on edge k gives out_valid=1 after edge k+WIDTH.
  - in_ready=0 throughout MUL.
  - out_valid=0 throughout MUL, because acceptance guaranteed the output register was empty or drained.
- in_valid and operand changes while in_ready=0 are ignored; no input is buffered.
- Unused opcode behaviour: none; all 16 opcodes are defined. MUL_EN=0 opcode 14 gives result=0, flags Z=1.
- Reset mid-MUL: the result never appears, and in_ready=1 after release.

Test Plan:
- ADD a=0x7FFF b=0x0001, out_ready=1 -> next cycle result=0x8000, flags V=1 C=0 N=1 Z=0.
- SUB a=0x0000 b=0x0001 -> result=0xFFFF, C=1 N=1 V=0 Z=0. Then SLT a=0xFFFF b=0x0001 -> result=0x0001, C=0.
- SRA a=0x8001 b=0x0001 -> result=0xC000, C=1 N=1. Then SHL a=0x8001 b=0x0000 -> result=0x8001, C=0.
- MUL a=0x0123 b=0x0045 accepted on edge k -> in_ready=0 for edges k+1..k+16, out_valid rises after edge k+16, result=0x4E6F, flags all 0.
- Backpressure, in this order:
  - Hold out_ready=0 and issue ADD 0x0002+0x0003 -> result=0x0005 holds stable and in_ready=0 for 5 cycles while a second op (XOR 0x00FF^0x0F0F) is presented.
  - Raise out_ready -> 0x0005 is consumed, XOR is accepted on the same edge, and the next cycle gives result=0x0FF0.
  - Streaming 8 ADDs with out_ready=1 -> 8 results on 8 consecutive cycles.
- Assert rst_n=0 asynchronously mid-MUL (count=7) -> out_valid, result and flags are 0 immediately, no stale product ever appears, and in_ready=1 on the first cycle after release.
